// File: rtl/imem_loadable.sv
// Instruction memory with a hardware clear sequence after reset, a streaming
// loader port and a registered fetch port.
// Fetch latency 1 cycle; fetch is only served in IDLE, and load_ready is high only in LOAD.
module imem_loadable #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 64,
   parameter int ADDR_W         = 6,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   input  logic              load_last,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              load_done,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_X     = (ADDR_W + 1)'(DEPTH);
   localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;
   logic                fetch_valid_q, fetch_valid_d;
   logic                load_done_q, load_done_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                fetch_in_range;
   logic                waddr_in_range;

   // Addresses at or beyond DEPTH read as zero and are never written.
   assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;
   assign waddr_in_range = {1'b0, mem_waddr} < DEPTH_X;

   // Next-state, pointer and write-port decode; one memory write port shared by clear and load.
   always_comb begin
      state_d       = state_q;
      clr_ptr_d     = clr_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      fetch_data_d  = fetch_data_q;
      fetch_valid_d = 1'b0;
      load_done_d   = 1'b0;
      mem_we        = 1'b0;
      mem_waddr     = wr_ptr_q;
      mem_wdata     = load_data;
      case (state_q)
         ST_CLEAR: begin
            // Walk every word to zero; requests arriving now are dropped.
            mem_we       = 1'b1;
            mem_waddr    = clr_ptr_q;
            mem_wdata    = '0;
            fetch_data_d = '0;
            if (clr_ptr_q == LAST_ADDR) begin
               clr_ptr_d = '0;
               state_d   = ST_IDLE;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         ST_IDLE: begin
            // A fetch in the same cycle as load_start is still served.
            if (fetch_en) begin
               fetch_valid_d = 1'b1;
               fetch_data_d  = fetch_in_range ? mem[fetch_addr] : '0;
            end
            if (load_start) begin
               state_d  = ST_LOAD;
               wr_ptr_d = load_base;
            end
         end
         ST_LOAD: begin
            // load_start is ignored here; fetch is blocked so reads never race writes.
            fetch_data_d = '0;
            if (load_valid) begin
               mem_we   = 1'b1;
               wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
               if (load_last) begin
                  state_d     = ST_IDLE;
                  load_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d      = ST_IDLE;
            fetch_data_d = '0;
         end
      endcase
   end

   // Control state and registered outputs; reset also aborts any burst in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RESET_STATE;
         clr_ptr_q     <= '0;
         wr_ptr_q      <= '0;
         fetch_data_q  <= '0;
         fetch_valid_q <= 1'b0;
         load_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_ptr_q     <= clr_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         fetch_data_q  <= fetch_data_d;
         fetch_valid_q <= fetch_valid_d;
         load_done_q   <= load_done_d;
      end
   end

   // Storage array has no reset; the clear sequence zeroes it instead.
   always_ff @(posedge clk) begin
      if (mem_we && waddr_in_range) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign load_ready  = (state_q == ST_LOAD);
   assign busy        = (state_q != ST_IDLE);
   assign fetch_data  = fetch_data_q;
   assign fetch_valid = fetch_valid_q;
   assign load_done   = load_done_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable (DEPTH=64): clear timing, loads, wrap,
// blocking of fetch during load, simultaneous start/fetch, and reset mid-burst.
module tb_imem_loadable;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic [5:0]  load_base = '0;
   logic        load_valid = 1'b0;
   logic        load_last = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_ready;
   logic        load_done;
   logic        fetch_en = 1'b0;
   logic [5:0]  fetch_addr = '0;
   logic [31:0] fetch_data;
   logic        fetch_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   imem_loadable #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .reset(reset),
      .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
      .load_last(load_last), .load_data(load_data), .load_ready(load_ready),
      .load_done(load_done), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
      .fetch_data(fetch_data), .fetch_valid(fetch_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [5:0] a, output logic [31:0] d, output logic v);
      fetch_en   = 1'b1;
      fetch_addr = a;
      tick();
      fetch_en   = 1'b0;
      d = fetch_data;
      v = fetch_valid;
   endtask

   // Counts cycles until busy drops (bounded), noting any load_done or fetch_valid seen.
   task automatic run_clear(output int n, output logic saw_done, output logic saw_fv);
      n = 0;
      saw_done = 1'b0;
      saw_fv = 1'b0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n++;
         if (load_done !== 1'b0) saw_done = 1'b1;
         if (fetch_valid !== 1'b0) saw_fv = 1'b1;
      end
   endtask

   task automatic load_burst(input logic [5:0] base, input int nbeats, input int gap, input bit finish,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      logic [31:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      load_start = 1'b1;
      load_base  = base;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         repeat (gap) tick();
         load_valid = 1'b1;
         load_data  = w[i];
         load_last  = finish && (i == nbeats - 1);
         tick();
         load_valid = 1'b0;
         load_last  = 1'b0;
      end
   endtask

   task automatic test_reset();
      int n;
      logic sd, sf;
      logic [31:0] d;
      logic v;
      logic [5:0] addrs [3];
      addrs[0] = 6'd0; addrs[1] = 6'd17; addrs[2] = 6'd63;
      reset = 1'b1;
      tick(); tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b required 0", load_ready); end
      checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h0) begin errors++; $display("FAIL reset_fetch: got valid %b data %h required 0/0", fetch_valid, fetch_data); end
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b required 0", load_done); end
      fetch_en = 1'b1;
      fetch_addr = 6'd5;
      reset = 1'b0;
      run_clear(n, sd, sf);
      fetch_en = 1'b0;
      checks++; if (n !== 64) begin errors++; $display("FAIL clear_cycles: got %0d required 64", n); end
      checks++; if (sf !== 1'b0) begin errors++; $display("FAIL clear_fetch_dropped: fetch_valid seen %b required 0", sf); end
      for (int i = 0; i < 3; i++) begin
         do_fetch(addrs[i], d, v);
         checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL clear_read addr %0d: got valid %b data %h required 1/0", addrs[i], v, d); end
      end
   endtask

   task automatic test_load_basic();
      logic [31:0] d;
      logic v;
      load_burst(6'd0, 4, 0, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44);
      checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b required 1", load_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_last: busy %b required 0", busy); end
      tick();
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b required 0", load_done); end
      do_fetch(6'd2, d, v);
      checks++; if (v !== 1'b1 || d !== 32'h33) begin errors++; $display("FAIL fetch2: got valid %b data %h required 1/00000033", v, d); end
      tick();
      checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h33) begin errors++; $display("FAIL fetch_hold: got valid %b data %h required 0/00000033", fetch_valid, fetch_data); end
      do_fetch(6'd3, d, v);
      checks++; if (v !== 1'b1 || d !== 32'h44) begin errors++; $display("FAIL fetch3: got %h required 00000044", d); end
   endtask

   task automatic test_gaps();
      logic [31:0] d;
      logic v;
      logic [5:0]  a [5];
      logic [31:0] e [5];
      a[0] = 6'd9;  e[0] = 32'h0;
      a[1] = 6'd10; e[1] = 32'hA1;
      a[2] = 6'd11; e[2] = 32'hA2;
      a[3] = 6'd12; e[3] = 32'hA3;
      a[4] = 6'd13; e[4] = 32'h0;
      load_burst(6'd10, 3, 2, 1'b1, 32'hA1, 32'hA2, 32'hA3, 32'h0);
      checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b required 1", load_done); end
      for (int i = 0; i < 5; i++) begin
         do_fetch(a[i], d, v);
         checks++; if (v !== 1'b1 || d !== e[i]) begin errors++; $display("FAIL gap_read addr %0d: got %h required %h", a[i], d, e[i]); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      logic v;
      logic [5:0]  a [5];
      logic [31:0] e [5];
      a[0] = 6'd62; e[0] = 32'hAAAA0001;
      a[1] = 6'd63; e[1] = 32'hBBBB0002;
      a[2] = 6'd0;  e[2] = 32'hCCCC0003;
      a[3] = 6'd1;  e[3] = 32'hDDDD0004;
      a[4] = 6'd2;  e[4] = 32'h33;
      load_burst(6'd62, 4, 0, 1'b1, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004);
      for (int i = 0; i < 5; i++) begin
         do_fetch(a[i], d, v);
         checks++; if (v !== 1'b1 || d !== e[i]) begin errors++; $display("FAIL wrap_read addr %0d: got %h required %h", a[i], d, e[i]); end
      end
   endtask

   task automatic test_fetch_blocked();
      logic [31:0] d;
      logic v;
      do_fetch(6'd62, d, v);
      load_start = 1'b1;
      load_base  = 6'd20;
      tick();
      load_start = 1'b0;
      checks++; if (load_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL load_state: ready %b busy %b required 1/1", load_ready, busy); end
      fetch_en = 1'b1;
      fetch_addr = 6'd62;
      tick();
      fetch_en = 1'b0;
      checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h0) begin errors++; $display("FAIL fetch_in_load: got valid %b data %h required 0/0", fetch_valid, fetch_data); end
      load_start = 1'b1; load_base = 6'd40;
      load_valid = 1'b1; load_data = 32'h51000001; load_last = 1'b0;
      tick();
      load_start = 1'b0;
      load_data = 32'h51000002; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b required 1", load_done); end
      do_fetch(6'd20, d, v);
      checks++; if (d !== 32'h51000001) begin errors++; $display("FAIL restart_addr20: got %h required 51000001", d); end
      do_fetch(6'd21, d, v);
      checks++; if (d !== 32'h51000002) begin errors++; $display("FAIL restart_addr21: got %h required 51000002", d); end
      do_fetch(6'd40, d, v);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL restart_addr40: got %h required 0", d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic v;
      fetch_en = 1'b1; fetch_addr = 6'd20;
      load_start = 1'b1; load_base = 6'd30;
      tick();
      fetch_en = 1'b0; load_start = 1'b0;
      checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h51000001) begin errors++; $display("FAIL simul_fetch: got valid %b data %h required 1/51000001", fetch_valid, fetch_data); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL simul_load_entered: got %b required 1", load_ready); end
      load_valid = 1'b1; load_data = 32'h66; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      do_fetch(6'd30, d, v);
      checks++; if (v !== 1'b1 || d !== 32'h66) begin errors++; $display("FAIL simul_addr30: got %h required 00000066", d); end
   endtask

   task automatic test_reset_mid_load();
      int n;
      logic sd, sf;
      logic [31:0] d;
      logic v;
      logic [5:0] a [9];
      a[0] = 6'd0; a[1] = 6'd1; a[2] = 6'd5; a[3] = 6'd6; a[4] = 6'd17;
      a[5] = 6'd20; a[6] = 6'd30; a[7] = 6'd62; a[8] = 6'd63;
      load_burst(6'd5, 2, 0, 1'b0, 32'h77, 32'h88, 32'h0, 32'h0);
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL async_reset: busy %b ready %b required 1/0", busy, load_ready); end
      tick(); tick();
      reset = 1'b0;
      run_clear(n, sd, sf);
      checks++; if (n !== 64) begin errors++; $display("FAIL reclear_cycles: got %0d required 64", n); end
      checks++; if (sd !== 1'b0) begin errors++; $display("FAIL reclear_no_done: load_done seen %b required 0", sd); end
      for (int i = 0; i < 9; i++) begin
         do_fetch(a[i], d, v);
         checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reclear_read addr %0d: got valid %b data %h required 1/0", a[i], v, d); end
      end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_gaps();
      test_wrap();
      test_fetch_blocked();
      test_back_to_back();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
